// File: rtl/ui_menu_fsm.sv
// GuyBox UI controller: button synchroniser/debouncer, tick divider and the
// WELCOME -> HOME -> APP menu state machine with a hold-to-exit gesture.
module ui_menu_fsm #(
  parameter int N_APPS    = 4,
  parameter int DIV_LOG2  = 3,
  parameter int DEB_TICKS = 4,
  parameter int EXIT_HOLD = 16,
  parameter int WRAP      = 1,
  localparam int CW = ($clog2(N_APPS) < 1) ? 1 : $clog2(N_APPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [7:0]    buttons,
  output logic [1:0]    state,
  output logic [CW-1:0] cursor,
  output logic [CW-1:0] app_sel,
  output logic          app_start,
  output logic          app_exit,
  output logic [7:0]    btn_press,
  output logic [7:0]    btn_level,
  output logic          tick
);

  localparam int DW = ($clog2(DEB_TICKS + 1) < 1) ? 1 : $clog2(DEB_TICKS + 1);
  localparam int HW = ($clog2(EXIT_HOLD + 1) < 1) ? 1 : $clog2(EXIT_HOLD + 1);
  localparam logic [CW-1:0] LAST = CW'(N_APPS - 1);

  // Button bit positions: {Start, C, B, A, Right, Left, Down, Up}
  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3;
  localparam int B_A = 4, B_B = 5, B_START = 7;

  typedef enum logic [1:0] {
    S_WELCOME = 2'd0,
    S_HOME    = 2'd1,
    S_APP     = 2'd2
  } state_t;

  state_t        st;
  logic [7:0]    sync1, sync2;
  logic [7:0]    lvl_d;
  logic [DW-1:0] deb_cnt [8];
  logic [HW-1:0] hold;
  logic          fwd, bwd;

  assign state = st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= buttons;
      sync2 <= sync1;
    end
  end

  generate
    if (DIV_LOG2 == 0) begin : g_nodiv
      assign tick = en;
    end else begin : g_div
      logic [DIV_LOG2-1:0] div_cnt;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)    div_cnt <= '0;
        else if (en) div_cnt <= div_cnt + 1'b1;
      end
      assign tick = en & (&div_cnt);
    end
  endgenerate

  // Press pulses come from the registered level edge, so a rise that lands in
  // a frozen cycle is lost rather than replayed once en returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_level <= '0;
      lvl_d     <= '0;
      btn_press <= '0;
      for (int unsigned i = 0; i < 8; i++) deb_cnt[i] <= '0;
    end else begin
      lvl_d     <= btn_level;
      btn_press <= en ? (btn_level & ~lvl_d) : '0;
      if (tick) begin
        for (int unsigned i = 0; i < 8; i++) begin
          if (sync2[i] != btn_level[i]) begin
            if (deb_cnt[i] == DW'(DEB_TICKS - 1)) begin
              btn_level[i] <= ~btn_level[i];
              deb_cnt[i]   <= '0;
            end else begin
              deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
          end else begin
            deb_cnt[i] <= '0;
          end
        end
      end
    end
  end

  always_comb begin
    fwd = btn_press[B_DOWN] | btn_press[B_RIGHT];
    bwd = btn_press[B_UP]   | btn_press[B_LEFT];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= S_WELCOME;
      cursor    <= '0;
      app_sel   <= '0;
      app_start <= 1'b0;
      app_exit  <= 1'b0;
      hold      <= '0;
    end else begin
      app_start <= 1'b0;
      app_exit  <= 1'b0;
      if (en) begin
        case (st)
          S_WELCOME: begin
            if (btn_press[B_START]) begin
              st     <= S_HOME;
              cursor <= '0;
            end
          end
          S_HOME: begin
            if (btn_press[B_A]) begin
              st        <= S_APP;
              app_sel   <= cursor;
              app_start <= 1'b1;
              hold      <= '0;
            end else if (fwd && !bwd) begin
              if (cursor == LAST) cursor <= (WRAP != 0) ? '0 : LAST;
              else                cursor <= cursor + 1'b1;
            end else if (bwd && !fwd) begin
              if (cursor == '0) cursor <= (WRAP != 0) ? LAST : '0;
              else              cursor <= cursor - 1'b1;
            end
          end
          S_APP: begin
            if (tick) begin
              if (btn_level[B_START] && btn_level[B_B]) begin
                if (hold == HW'(EXIT_HOLD - 1)) begin
                  st       <= S_HOME;
                  cursor   <= app_sel;
                  app_exit <= 1'b1;
                  hold     <= '0;
                end else begin
                  hold <= hold + 1'b1;
                end
              end else begin
                hold <= '0;
              end
            end
          end
          default: st <= S_WELCOME;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ui_menu_fsm.sv
// Self-checking bench for ui_menu_fsm: a fast wrapping instance scoreboarded on
// its pulse outputs, plus a divided, saturating instance checked on cursor/tick.
module tb_ui_menu_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b1;
  logic [7:0] buttons   = '0;
  logic [7:0] buttons_s = '0;

  logic [1:0] state, s_state;
  logic [1:0] cursor, app_sel, s_cursor, s_app_sel;
  logic       app_start, app_exit, tick, s_app_start, s_app_exit, s_tick;
  logic [7:0] btn_press, btn_level, s_press, s_level;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [9:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ui_menu_fsm #(.N_APPS(4), .DIV_LOG2(0), .DEB_TICKS(4), .EXIT_HOLD(16), .WRAP(1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .buttons(buttons),
    .state(state), .cursor(cursor), .app_sel(app_sel),
    .app_start(app_start), .app_exit(app_exit),
    .btn_press(btn_press), .btn_level(btn_level), .tick(tick)
  );

  ui_menu_fsm #(.N_APPS(4), .DIV_LOG2(2), .DEB_TICKS(4), .EXIT_HOLD(16), .WRAP(0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .buttons(buttons_s),
    .state(s_state), .cursor(s_cursor), .app_sel(s_app_sel),
    .app_start(s_app_start), .app_exit(s_app_exit),
    .btn_press(s_press), .btn_level(s_level), .tick(s_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every pulse the fast instance produces must match the next expected event.
  always @(negedge clk) begin
    if (rst === 1'b1 && {app_exit, app_start, btn_press} != 10'h0) begin
      if (exp_q.size() == 0) check("spurious_evt", {22'h0, app_exit, app_start, btn_press}, 32'h0);
      else                   check("evt", {22'h0, app_exit, app_start, btn_press}, {22'h0, exp_q.pop_front()});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] m, input logic [1:0] follow);
    exp_q.push_back({2'b00, m});
    if (follow != 2'b00) exp_q.push_back({follow, 8'h00});
    buttons   = m;
    buttons_s = m;
    cycles(40);
    buttons   = '0;
    buttons_s = '0;
    cycles(40);
  endtask

  function automatic int nav(input int cur, input logic [7:0] m, input int wrap);
    logic f, b;
    f = m[1] | m[3];
    b = m[0] | m[2];
    if (f && !b) return (cur == 3) ? ((wrap != 0) ? 0 : 3) : cur + 1;
    if (b && !f) return (cur == 0) ? ((wrap != 0) ? 3 : 0) : cur - 1;
    return cur;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cur, scur, n, ticks;
    bit found;
    logic [7:0] seq [15];
    seq = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01,
            8'h03, 8'h0A, 8'h05, 8'h02, 8'h02, 8'h80};

    cycles(3);
    check("rst_state", 32'(state), 32'd0);
    check("rst_cursor", 32'(cursor), 32'd0);
    check("rst_app_sel", 32'(app_sel), 32'd0);
    check("rst_level", 32'(btn_level), 32'd0);
    check("rst_pulses", {22'h0, app_exit, app_start, btn_press}, 32'h0);
    rst = 1'b1;
    cycles(2);
    check("tick_nodiv", 32'(tick), 32'd1);
    ticks = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (s_tick) ticks++;
    end
    check("tick_div4_count", 32'(ticks), 32'd4);
    cycles(1);

    // Boot: Start held long gives exactly one pulse.
    exp_q.push_back(10'h080);
    buttons = 8'h80; buttons_s = 8'h80;
    cycles(200);
    check("boot_state", 32'(state), 32'd1);
    check("boot_cursor", 32'(cursor), 32'd0);
    check("boot_level", 32'(btn_level[7]), 32'd1);
    buttons = '0; buttons_s = '0;
    cycles(40);
    check("sat_boot_state", 32'(s_state), 32'd1);

    // Debounce: bouncing Down never settles, then one press after the final rise.
    for (int i = 0; i < 5; i++) begin
      buttons = 8'h02; cycles(2);
      buttons = 8'h00; cycles(2);
    end
    exp_q.push_back(10'h002);
    buttons = 8'h02;
    n = 0; found = 0;
    while (!found && n < 50) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (btn_press[1]) found = 1;
    end
    check("deb_latency", 32'(n), 32'd7);
    cycles(20);
    buttons = '0;
    cycles(40);
    cur = 1; scur = 0;
    check("deb_cursor", 32'(cursor), 32'(cur));

    // Navigation: wrap on the fast instance, saturation on the slow one.
    foreach (seq[k]) begin
      press(seq[k], 2'b00);
      cur  = nav(cur, seq[k], 1);
      scur = nav(scur, seq[k], 0);
      check("nav_cursor_wrap", 32'(cursor), 32'(cur));
      check("nav_cursor_sat", 32'(s_cursor), 32'(scur));
    end
    check("home_state", 32'(state), 32'd1);

    // Launch: A wins over Down in the same cycle.
    press(8'h12, 2'b01);
    check("launch_state", 32'(state), 32'd2);
    check("launch_app_sel", 32'(app_sel), 32'd2);
    check("launch_cursor", 32'(cursor), 32'd2);
    check("sat_launch_state", 32'(s_state), 32'd2);
    check("sat_launch_app_sel", 32'(s_app_sel), 32'd2);

    // Hold exit: 15 ticks is one short, then a full 16-tick hold exits once.
    exp_q.push_back(10'h0A0);
    buttons = 8'hA0;
    cycles(15);
    buttons = 8'h80;
    cycles(20);
    check("short_hold_state", 32'(state), 32'd2);
    exp_q.push_back(10'h020);
    exp_q.push_back(10'h200);
    buttons = 8'hA0;
    cycles(40);
    buttons = '0;
    cycles(40);
    check("exit_state", 32'(state), 32'd1);
    check("exit_cursor", 32'(cursor), 32'd2);
    check("exit_app_sel", 32'(app_sel), 32'd2);

    // Enable: freeze Start mid-debounce, resume and finish the remaining ticks.
    buttons = 8'h80;
    cycles(4);
    en = 1'b0;
    cycles(5);
    check("frozen_tick", 32'(tick), 32'd0);
    check("frozen_sat_tick", 32'(s_tick), 32'd0);
    check("frozen_level", 32'(btn_level[7]), 32'd0);
    cycles(5);
    exp_q.push_back(10'h080);
    en = 1'b1;
    n = 0; found = 0;
    while (!found && n < 50) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (btn_press[7]) found = 1;
    end
    check("resume_latency", 32'(n), 32'd3);
    cycles(10);
    buttons = '0;
    cycles(40);
    check("resume_state", 32'(state), 32'd1);

    // Reset mid-hold in APP.
    press(8'h10, 2'b01);
    check("relaunch_state", 32'(state), 32'd2);
    exp_q.push_back(10'h0A0);
    buttons = 8'hA0;
    cycles(15);
    rst = 1'b0;
    #1;
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_cursor", 32'(cursor), 32'd0);
    check("midrst_app_sel", 32'(app_sel), 32'd0);
    check("midrst_level", 32'(btn_level), 32'd0);
    check("midrst_pulses", {22'h0, app_exit, app_start, btn_press}, 32'h0);
    buttons = '0;
    cycles(5);
    rst = 1'b1;
    cycles(40);
    check("post_rst_state", 32'(state), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ui_menu_fsm.md
Name: ui_menu_fsm

Overview:
- Parametrised GuyBox UI state machine, the successor to the fixed 4-state UI FSM.
- Synchronises and debounces the 8 raw controller buttons and generates one-cycle press pulses.
- Runs a WELCOME -> HOME -> APP flow with a wrap-around cursor over N_APPS home-screen entries and a hold-to-exit gesture.
- Sits between the controller input block and the processor/graphics side; the processor reads `state`, `cursor` and `app_sel` and reacts to `app_start`/`app_exit`.

Parameters:
- N_APPS, 4: number of selectable home-screen entries (>=2).
- DIV_LOG2, 3: width of the tick divider; `tick` fires every 2^DIV_LOG2 clk cycles. 0 means every cycle.
- DEB_TICKS, 4: consecutive ticks a synchronised button must differ from its stable value before the stable value flips (>=1).
- EXIT_HOLD, 16: ticks Start+B must be held in APP before exit (>=1).
- WRAP, 1: 1 = cursor wraps at the ends; 0 = cursor saturates.
- CW is derived: CW = max(1, clog2(N_APPS)).

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous, active-low reset
- en  in  1  global enable; low freezes all state
- buttons  in  8  raw {Start, C, B, A, Right, Left, Down, Up}, asynchronous to clk
- state  out  2  0 = WELCOME, 1 = HOME, 2 = APP (3 is never driven)
- cursor  out  CW  highlighted home-screen entry
- app_sel  out  CW  entry latched on launch
- app_start  out  1  one-clk pulse on entering APP
- app_exit  out  1  one-clk pulse on APP -> HOME
- btn_press  out  8  one-clk debounced rising-edge pulses, same bit order as `buttons`
- btn_level  out  8  debounced stable button levels
- tick  out  1  divider strobe

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = WELCOME; cursor = 0; app_sel = 0.
  - btn_level = 0; btn_press = 0; app_start = 0; app_exit = 0.
  - Divider, debounce counters and hold counter = 0; synchroniser flops = 0.
  - Release is not re-synchronised inside this block; the top level supplies a synchronised deassertion.
- Synchroniser: every bit of `buttons` passes through a 2-flop synchroniser (2-cycle latency). The synchroniser always runs, regardless of en.
- Divider:
  - DIV_LOG2-bit counter increments each clk while en = 1 and wraps naturally.
  - tick = en & (counter all-ones).
  - DIV_LOG2 = 0: tick = en.
- Debounce, per bit, evaluated only on tick:
  - If the synchronised bit differs from btn_level, increment that bit's counter; otherwise clear it.
  - When the counter would reach DEB_TICKS, flip btn_level and clear the counter.
  - btn_press[i] is registered high for exactly the one clk cycle after btn_level[i] goes 0->1. 1->0 transitions produce no pulse.
- FSM: acts only in cycles where btn_press is nonzero (for press-driven moves) or on tick (for the hold counter); otherwise it holds.
- WELCOME:
  - Start press -> HOME, cursor = 0.
  - Any other press is ignored.
- HOME:
  - A press -> APP; app_sel <= cursor; app_start = 1 next cycle.
  - A has priority over navigation in the same cycle.
  - Down or Right press -> cursor + 1. Up or Left press -> cursor - 1.
  - Forward and backward presses in the same cycle -> no move. Down+Right together counts as one step (likewise Up+Left).
  - At N_APPS-1 + 1: cursor -> 0 if WRAP, else holds N_APPS-1. At 0 - 1: cursor -> N_APPS-1 if WRAP, else holds 0.
  - Start press in HOME does nothing.
- APP:
  - Hold counter increments on tick while btn_level Start and B are both 1; it clears on any tick where either is 0.
  - When it would reach EXIT_HOLD -> HOME; cursor <= app_sel; app_exit = 1 next cycle; counter cleared.
  - All other presses are reported on btn_press only; no state change.
- app_start and app_exit are never high in the same cycle and never high for more than one cycle.
- en = 0:
  - Divider, debounce, hold counter and FSM are frozen; cursor, app_sel, btn_level and state hold.
  - btn_press, app_start and app_exit are forced to 0.
  - A pulse due in the frozen cycle is dropped, not deferred.
- Reset asserted mid-hold or mid-debounce: every counter returns to 0 and state returns to WELCOME; no pulse is emitted.
- Latency, for DIV_LOG2 = 0, en = 1, raw bit held stable: btn_press is high in the cycle 2 + DEB_TICKS + 1 clk edges after the first edge that samples the raw bit high.

Test Plan:
- Reset then boot (defaults): hold Start 200 cycles -> btn_press[7] pulses once for 1 cycle; state goes 0 -> 1; cursor = 0; no further pulse while Start is held.
- Debounce (DIV_LOG2 = 0, DEB_TICKS = 4): Down toggles every 2 cycles for 20 cycles, then holds high -> no btn_press[1] while toggling; exactly one pulse 7 cycles after the final rise; cursor 0 -> 1.
- Wrap (N_APPS = 4, WRAP = 1): from cursor 3, Down press -> cursor 0; then Up press -> cursor 3. With WRAP = 0: cursor 3 plus Down -> stays 3; cursor 0 plus Up -> stays 0.
- Launch and priority: cursor = 2, A and Down pressed in the same cycle -> state = 2, app_sel = 2, cursor unchanged, app_start pulses once.
- Hold exit (EXIT_HOLD = 16): in APP, hold Start+B 15 ticks, release B, hold again 16 ticks -> exactly one app_exit after the second hold; state = 1; cursor = app_sel.
- Enable and reset: deassert en while Start is debouncing -> no pulse and counters frozen; reassert en -> pulse arrives after the remaining ticks. Pull rst low mid-hold in APP -> outputs immediately return to reset values and state = 0.
